// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial IF/MEM memory controller for the 8-bit RAM/IO bus
// Optional busy_cnt_out port and counter enabled by defining MEM_CTRL_BUSY_CNT_EN.
module mem_ctrl #(
    parameter int ADDR_W   = 32,
    parameter bit MEM_PRIO = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    input  logic              if_flush_in,
    output logic              if_done_out,
    output logic [31:0]       if_inst_out,
    input  logic              mem_req_in,
    input  logic              mem_wr_in,
    input  logic [1:0]        mem_len_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [31:0]       mem_wdata_in,
    output logic              mem_done_out,
    output logic [31:0]       mem_rdata_out,
    input  logic [7:0]        ram_din_in,
    output logic [7:0]        ram_dout_out,
    output logic [ADDR_W-1:0] ram_a_out,
    output logic              ram_wr_out
`ifdef MEM_CTRL_BUSY_CNT_EN
    ,
    output logic [31:0]       busy_cnt_out
`endif
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] ramA;
    logic              ramWr;
    logic [7:0]        ramDout;
    logic [2:0]        cyc;
    logic [2:0]        nBytes;
    logic [31:0]       buffer;
    logic [31:0]       ifInst;
    logic [31:0]       memRdata;
    logic              ifDone;
    logic              memDone;

    logic              ifTake;
    logic              memTake;
    logic [1:0]        capLane;
    logic [31:0]       capBuf;

    // A requester still holds req during its own done cycle; that level must not start a new access.
    always_comb begin
        ifTake  = if_req_in & ~ifDone & ~if_flush_in;
        memTake = mem_req_in & ~memDone;
        capLane = 2'(cyc - 3'd2);
        capBuf  = buffer;
        capBuf[8*capLane +: 8] = ram_din_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            ramA     <= '0;
            ramWr    <= 1'b0;
            ramDout  <= 8'h00;
            cyc      <= 3'd0;
            nBytes   <= 3'd0;
            buffer   <= 32'h0;
            ifInst   <= 32'h0;
            memRdata <= 32'h0;
            ifDone   <= 1'b0;
            memDone  <= 1'b0;
        end else if (rdy_in) begin
            ifDone  <= 1'b0;
            memDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (memTake && (MEM_PRIO || !ifTake)) begin
                        ramA   <= mem_addr_in;
                        cyc    <= 3'd1;
                        nBytes <= {1'b0, mem_len_in} + 3'd1;
                        if (mem_wr_in) begin
                            state   <= MEM_WR;
                            ramWr   <= 1'b1;
                            ramDout <= mem_wdata_in[7:0];
                            buffer  <= mem_wdata_in;
                        end else begin
                            state  <= MEM_RD;
                            buffer <= 32'h0;
                        end
                    end else if (ifTake) begin
                        state  <= IF_RD;
                        ramA   <= if_addr_in;
                        cyc    <= 3'd1;
                        nBytes <= 3'd4;
                        buffer <= 32'h0;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state == IF_RD && if_flush_in) begin
                        state <= IDLE;
                        ramA  <= '0;
                    end else begin
                        // RAM answers one cycle after the address, so capture trails issue by one.
                        ramA <= (cyc < nBytes) ? ramA + ADDR_ONE : '0;
                        if (cyc >= 3'd2) begin
                            buffer <= capBuf;
                        end
                        if (cyc == nBytes + 3'd1) begin
                            state <= IDLE;
                            if (state == IF_RD) begin
                                ifDone <= 1'b1;
                                ifInst <= capBuf;
                            end else begin
                                memDone  <= 1'b1;
                                memRdata <= capBuf;
                            end
                        end
                        cyc <= cyc + 3'd1;
                    end
                end
                MEM_WR: begin
                    if (cyc < nBytes) begin
                        ramA    <= ramA + ADDR_ONE;
                        ramDout <= buffer[8*cyc[1:0] +: 8];
                        cyc     <= cyc + 3'd1;
                    end else begin
                        state   <= IDLE;
                        ramA    <= '0;
                        ramDout <= 8'h00;
                        ramWr   <= 1'b0;
                        memDone <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ram_a_out     = ramA;
    assign ram_wr_out    = ramWr & rdy_in;
    assign ram_dout_out  = ramDout;
    assign if_done_out   = ifDone;
    assign if_inst_out   = ifInst;
    assign mem_done_out  = memDone;
    assign mem_rdata_out = memRdata;

`ifdef MEM_CTRL_BUSY_CNT_EN
    logic [31:0] busyCnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busyCnt <= 32'h0;
        end else if (rdy_in && state != IDLE) begin
            busyCnt <= busyCnt + 32'd1;
        end
    end

    assign busy_cnt_out = busyCnt;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with bus RAM and reference memory
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        if_req_in, if_flush_in;
    logic [31:0] if_addr_in;
    logic        mem_req_in, mem_wr_in;
    logic [1:0]  mem_len_in;
    logic [31:0] mem_addr_in, mem_wdata_in;
    logic [7:0]  ram_din_in;
    logic        if_done_out, mem_done_out, ram_wr_out;
    logic [31:0] if_inst_out, mem_rdata_out, ram_a_out;
    logic [7:0]  ram_dout_out;
`ifdef MEM_CTRL_BUSY_CNT_EN
    logic [31:0] busyCnt;
`endif

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_flush_in(if_flush_in),
        .if_done_out(if_done_out), .if_inst_out(if_inst_out),
        .mem_req_in(mem_req_in), .mem_wr_in(mem_wr_in), .mem_len_in(mem_len_in),
        .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
        .mem_done_out(mem_done_out), .mem_rdata_out(mem_rdata_out),
        .ram_din_in(ram_din_in), .ram_dout_out(ram_dout_out),
        .ram_a_out(ram_a_out), .ram_wr_out(ram_wr_out)
`ifdef MEM_CTRL_BUSY_CNT_EN
        , .busy_cnt_out(busyCnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Platform RAM: 4 KiB aliased window, frozen with rdy_in like the real board.
    logic [7:0]  pmem [4096];
    logic        memInit = 1'b0, bdWe = 1'b0;
    logic [11:0] bdAddr;
    logic [7:0]  bdData;
    logic [7:0]  refMem [4096];

    function automatic logic [7:0] initByte(input int i);
        return 8'((i * 37) ^ (i >> 4) ^ 8'h5A);
    endfunction

    always @(posedge clk_in) begin
        if (memInit) begin
            for (int i = 0; i < 4096; i++) pmem[i] <= initByte(i);
        end else if (bdWe) begin
            pmem[bdAddr] <= bdData;
        end else if (rdy_in) begin
            if (ram_wr_out) pmem[ram_a_out[11:0]] <= ram_dout_out;
            ram_din_in <= pmem[ram_a_out[11:0]];
        end
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] lastRd;
    int lastDoneCyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bdWrite(input logic [11:0] a, input logic [7:0] d);
        bdAddr = a;
        bdData = d;
        bdWe   = 1'b1;
        @(posedge clk_in); #1;
        bdWe = 1'b0;
        refMem[a] = d;
    endtask

    // stallMode: 0 none, 1 random rdy drops before done, 2 rdy low in cycles 2..4
    task automatic runTxn(input bit isIf, input bit wr, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata, input int stallMode);
        int n, doneP, p, doneCyc;
        bit isWr;
        bit lastRdy;
        logic [31:0] expData;
        logic [7:0]  expDout;
        isWr  = wr && !isIf;
        n     = isIf ? 4 : int'(len) + 1;
        doneP = isWr ? n + 1 : n + 2;
        expData = 32'h0;
        for (int k = 0; k < n; k++) expData[8*k +: 8] = refMem[12'(addr + 32'(k))];
        @(posedge clk_in); #1;
        if (isIf) begin
            if_req_in  = 1'b1;
            if_addr_in = addr;
        end else begin
            mem_req_in   = 1'b1;
            mem_wr_in    = wr;
            mem_len_in   = len;
            mem_addr_in  = addr;
            mem_wdata_in = wdata;
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("idleAddr", ram_a_out, 32'h0);
        p = 1;
        lastRdy = 1'b1;
        doneCyc = 0;
        for (int c = 1; c <= 40 && doneCyc == 0; c++) begin
            @(posedge clk_in); #1;
            if (c > 1 && lastRdy) p++;
            if (stallMode == 1) rdy_in = (p < doneP && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            else if (stallMode == 2) rdy_in = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            else rdy_in = 1'b1;
            lastRdy = rdy_in;
            @(negedge clk_in);
            expDout = (isWr && p <= n) ? wdata[8*(p-1) +: 8] : 8'h00;
            check("busAddr", ram_a_out, (p <= n) ? addr + 32'(p - 1) : 32'h0);
            check("busWr", 32'(ram_wr_out), 32'(isWr && p <= n && rdy_in));
            check("busDout", 32'(ram_dout_out), 32'(expDout));
            check("ifDone", 32'(if_done_out), 32'(isIf && p == doneP));
            check("memDone", 32'(mem_done_out), 32'(!isIf && p == doneP));
            if (p == doneP) begin
                doneCyc = c;
                if (!isWr) begin
                    lastRd = isIf ? if_inst_out : mem_rdata_out;
                    check("rdData", lastRd, expData);
                end
            end
        end
        check("doneSeen", 32'(doneCyc != 0), 32'd1);
        lastDoneCyc = doneCyc;
        if (isWr) for (int k = 0; k < n; k++) refMem[12'(addr + 32'(k))] = wdata[8*k +: 8];
        @(posedge clk_in); #1;
        if_req_in  = 1'b0;
        mem_req_in = 1'b0;
        rdy_in     = 1'b1;
        @(negedge clk_in);
        check("reqIgnoredInDone", ram_a_out, 32'h0);
        check("reqIgnoredWr", 32'(ram_wr_out), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int memDc, ifDc, cnt30;
        logic [31:0] expInst;
        logic [31:0] expB;
        logic        isIfR, wrR;
        logic [1:0]  lenR;
        logic [31:0] addrR;

        rst_in = 1'b1; rdy_in = 1'b1;
        if_req_in = 1'b0; if_flush_in = 1'b0; if_addr_in = 32'h0;
        mem_req_in = 1'b0; mem_wr_in = 1'b0; mem_len_in = 2'd0;
        mem_addr_in = 32'h0; mem_wdata_in = 32'h0;
        for (int i = 0; i < 4096; i++) refMem[i] = initByte(i);
        memInit = 1'b1;
        @(posedge clk_in); #1;
        memInit = 1'b0;
        @(posedge clk_in); #1;
        check("rstAddr", ram_a_out, 32'h0);
        check("rstWr", 32'(ram_wr_out), 32'd0);
        check("rstDout", 32'(ram_dout_out), 32'd0);
        check("rstIfDone", 32'(if_done_out), 32'd0);
        check("rstMemDone", 32'(mem_done_out), 32'd0);
        check("rstInst", if_inst_out, 32'h0);
        check("rstRdata", mem_rdata_out, 32'h0);
        rst_in = 1'b0;

        // Fetch of 13 05 00 00 at 0x100
        bdWrite(12'h100, 8'h13);
        bdWrite(12'h101, 8'h05);
        bdWrite(12'h102, 8'h00);
        bdWrite(12'h103, 8'h00);
        runTxn(1'b1, 1'b0, 2'd3, 32'h100, 32'h0, 0);
        check("t1Inst", lastRd, 32'h00000513);
        check("t1DoneCyc", 32'(lastDoneCyc), 32'd6);

        // Word store
        runTxn(1'b0, 1'b1, 2'd3, 32'h200, 32'h11223344, 0);
        check("t2DoneCyc", 32'(lastDoneCyc), 32'd5);

        // Simultaneous fetch @0 and IO byte load @0x30000, MEM wins
        expInst = {refMem[3], refMem[2], refMem[1], refMem[0]};
        expB    = {24'h0, refMem[0]};
        memDc = 0; ifDc = 0; cnt30 = 0;
        @(posedge clk_in); #1;
        if_req_in = 1'b1; if_addr_in = 32'h0;
        mem_req_in = 1'b1; mem_wr_in = 1'b0; mem_len_in = 2'd0; mem_addr_in = 32'h30000;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk_in); #1;
            if (memDc != 0 && c == memDc + 1) mem_req_in = 1'b0;
            if (ifDc != 0 && c == ifDc + 1) if_req_in = 1'b0;
            @(negedge clk_in);
            if (ram_a_out == 32'h30000) cnt30++;
            if (c >= 4 && c <= 7) check("t3FetchAddr", ram_a_out, 32'(c - 4));
            if (mem_done_out) begin
                memDc = c;
                check("t3Rdata", mem_rdata_out, expB);
            end
            if (if_done_out) begin
                ifDc = c;
                check("t3Inst", if_inst_out, expInst);
            end
        end
        check("t3IoOnce", 32'(cnt30), 32'd1);
        check("t3MemDoneCyc", 32'(memDc), 32'd3);
        check("t3IfDoneCyc", 32'(ifDc), 32'd9);

        // Flush mid-fetch, then flush blocking acceptance in IDLE
        @(posedge clk_in); #1;
        if_req_in = 1'b1; if_addr_in = 32'h80;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("t4Addr1", ram_a_out, 32'h80);
        @(posedge clk_in); #1;
        if_flush_in = 1'b1;
        @(negedge clk_in);
        check("t4Addr2", ram_a_out, 32'h81);
        @(posedge clk_in); #1;
        if_flush_in = 1'b0; if_req_in = 1'b0;
        @(negedge clk_in);
        check("t4Addr3", ram_a_out, 32'h0);
        ifDc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            if (if_done_out) ifDc++;
        end
        check("t4NoDone", 32'(ifDc), 32'd0);
        @(posedge clk_in); #1;
        if_req_in = 1'b1; if_flush_in = 1'b1; if_addr_in = 32'h40;
        @(posedge clk_in); #1;
        if_req_in = 1'b0; if_flush_in = 1'b0;
        @(negedge clk_in);
        check("t4FlushBlocksIdle", ram_a_out, 32'h0);
        runTxn(1'b1, 1'b0, 2'd3, 32'h40, 32'h0, 0);

        // Word load with rdy low in cycles 2..4
        runTxn(1'b0, 1'b0, 2'd3, 32'h200, 32'h0, 2);
        check("t5DoneCyc", 32'(lastDoneCyc), 32'd9);
        check("t5Data", lastRd, 32'h11223344);

        // Reset in cycle 2 of a word store
        @(posedge clk_in); #1;
        mem_req_in = 1'b1; mem_wr_in = 1'b1; mem_len_in = 2'd3;
        mem_addr_in = 32'h300; mem_wdata_in = 32'hA1B2C3D4;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        mem_req_in = 1'b0;
        #1;
        check("t6Addr", ram_a_out, 32'h0);
        check("t6Wr", 32'(ram_wr_out), 32'd0);
        check("t6Dout", 32'(ram_dout_out), 32'd0);
        check("t6Done", 32'(mem_done_out), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        check("t6Byte0", 32'(pmem[12'h300]), 32'h000000D4);
        check("t6Byte1", 32'(pmem[12'h301]), 32'(refMem[12'h301]));
        refMem[12'h300] = 8'hD4;
        runTxn(1'b0, 1'b0, 2'd3, 32'h300, 32'h0, 0);

        // Random traffic with random stalls; stores are read back
        for (int t = 0; t < 40; t++) begin
            isIfR = ($urandom_range(0, 2) == 0);
            wrR   = isIfR ? 1'b0 : 1'($urandom_range(0, 1));
            lenR  = 2'($urandom_range(0, 3));
            addrR = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
            runTxn(isIfR, wrR, lenR, addrR, $urandom, 1);
            if (wrR) runTxn(1'b0, 1'b0, lenR, addrR, 32'h0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
